// File: rtl/mem_arbiter.sv
// mem_arbiter: one-outstanding memory port shared by icache and dcache; define MEM_ARB_RR_EN for round-robin grant
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ic_req_valid_i,
    output logic              ic_req_ready_o,
    input  logic [ADDR_W-1:0] ic_addr_i,
    input  logic              ic_flush_i,
    output logic              ic_rsp_valid_o,
    input  logic              ic_rsp_ready_i,
    output logic [DATA_W-1:0] ic_rsp_data_o,
    output logic [ADDR_W-1:0] ic_rsp_addr_o,
    input  logic              dc_req_valid_i,
    output logic              dc_req_ready_o,
    input  logic [ADDR_W-1:0] dc_addr_i,
    input  logic              dc_we_i,
    input  logic [DATA_W-1:0] dc_wdata_i,
    output logic              dc_rsp_valid_o,
    input  logic              dc_rsp_ready_i,
    output logic [DATA_W-1:0] dc_rsp_data_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_rsp_valid_i,
    output logic              mem_rsp_ready_o,
    input  logic [DATA_W-1:0] mem_rsp_data_i,
    input  logic [ADDR_W-1:0] mem_rsp_addr_i
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;
    state_t state_q, state_d;
    logic owner_ic_q, owner_ic_d, drop_q, drop_d, we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d, raddr_q, raddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic dc_elig, ic_elig, gnt_dc, gnt_ic, fl_ic;
    assign dc_elig = state_q == IDLE && !rst_i && dc_req_valid_i;
    assign ic_elig = state_q == IDLE && !rst_i && ic_req_valid_i && !ic_flush_i;
    assign fl_ic = ic_flush_i && owner_ic_q;
`ifdef MEM_ARB_RR_EN
    logic last_ic_q;
    assign gnt_dc = dc_elig && (!ic_elig || last_ic_q);
    assign gnt_ic = ic_elig && (!dc_elig || !last_ic_q);
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) last_ic_q <= 1'b1;
        else if (gnt_dc || gnt_ic) last_ic_q <= gnt_ic;
`else
    assign gnt_dc = dc_elig;
    assign gnt_ic = ic_elig && !dc_elig;
`endif
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_ic_q <= 1'b0;
            drop_q <= 1'b0;
            we_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            raddr_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_ic_q <= owner_ic_d;
            drop_q <= drop_d;
            we_q <= we_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            raddr_q <= raddr_d;
            rdata_q <= rdata_d;
        end
    end
    always_comb begin
        state_d = state_q;
        owner_ic_d = owner_ic_q;
        drop_d = drop_q;
        we_d = we_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        raddr_d = raddr_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (gnt_dc || gnt_ic) begin
                state_d = REQ;
                owner_ic_d = gnt_ic;
                addr_d = gnt_ic ? ic_addr_i : dc_addr_i;
                we_d = gnt_dc && dc_we_i;
                wdata_d = gnt_ic ? '0 : dc_wdata_i;
            end
            REQ: begin
                drop_d = drop_q || fl_ic;
                if (mem_req_ready_i) state_d = WAIT;
            end
            WAIT: if (mem_rsp_valid_i) begin
                rdata_d = mem_rsp_data_i;
                raddr_d = mem_rsp_addr_i;
                state_d = (drop_q || fl_ic) ? IDLE : RSP;
                drop_d = 1'b0;
            end else drop_d = drop_q || fl_ic;
            RSP: if (fl_ic || (owner_ic_q ? ic_rsp_ready_i : dc_rsp_ready_i)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        ic_req_ready_o = gnt_ic;
        dc_req_ready_o = gnt_dc;
        mem_req_valid_o = state_q == REQ;
        mem_rsp_ready_o = state_q == WAIT;
        ic_rsp_valid_o = state_q == RSP && owner_ic_q && !ic_flush_i;
        dc_rsp_valid_o = state_q == RSP && !owner_ic_q;
        mem_addr_o = addr_q;
        mem_we_o = we_q;
        mem_wdata_o = wdata_q;
        ic_rsp_data_o = rdata_q;
        ic_rsp_addr_o = raddr_q;
        dc_rsp_data_o = rdata_q;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a transaction-level reference model
module tb_mem_arbiter;
    logic clk = 0, rst = 1;
    logic ic_req_valid = 0, ic_flush = 0, ic_rsp_ready = 0;
    logic [31:0] ic_addr = 0;
    logic dc_req_valid = 0, dc_we = 0, dc_rsp_ready = 0;
    logic [31:0] dc_addr = 0, dc_wdata = 0;
    logic mem_req_ready = 0, mem_rsp_valid = 0;
    logic [31:0] mem_rsp_data = 0, mem_rsp_addr = 0;
    logic ic_req_ready_o, ic_rsp_valid_o, dc_req_ready_o, dc_rsp_valid_o;
    logic mem_req_valid_o, mem_we_o, mem_rsp_ready_o;
    logic [31:0] ic_rsp_data_o, ic_rsp_addr_o, dc_rsp_data_o, mem_addr_o, mem_wdata_o;
    int errors = 0, checks = 0, ic_seen = 0;
    bit m_busy, m_ic, m_iss, m_ans, m_disc, m_we, m_last_ic;
    logic [31:0] m_addr, m_wdata, m_rdata, m_raddr;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .ic_req_valid_i(ic_req_valid), .ic_req_ready_o(ic_req_ready_o), .ic_addr_i(ic_addr),
        .ic_flush_i(ic_flush), .ic_rsp_valid_o(ic_rsp_valid_o), .ic_rsp_ready_i(ic_rsp_ready),
        .ic_rsp_data_o(ic_rsp_data_o), .ic_rsp_addr_o(ic_rsp_addr_o),
        .dc_req_valid_i(dc_req_valid), .dc_req_ready_o(dc_req_ready_o), .dc_addr_i(dc_addr),
        .dc_we_i(dc_we), .dc_wdata_i(dc_wdata), .dc_rsp_valid_o(dc_rsp_valid_o),
        .dc_rsp_ready_i(dc_rsp_ready), .dc_rsp_data_o(dc_rsp_data_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o), .mem_rsp_valid_i(mem_rsp_valid),
        .mem_rsp_ready_o(mem_rsp_ready_o), .mem_rsp_data_i(mem_rsp_data), .mem_rsp_addr_i(mem_rsp_addr)
    );

    function automatic bit ie();
        return !m_busy && !rst && ic_req_valid && !ic_flush;
    endfunction
    function automatic bit de();
        return !m_busy && !rst && dc_req_valid;
    endfunction
    function automatic bit gd();
        return RR ? de() && (!ie() || m_last_ic) : de();
    endfunction
    function automatic bit gi();
        return RR ? ie() && (!de() || !m_last_ic) : ie() && !de();
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 0; m_ic <= 0; m_iss <= 0; m_ans <= 0; m_disc <= 0; m_we <= 0; m_last_ic <= 1;
            m_addr <= 0; m_wdata <= 0; m_rdata <= 0; m_raddr <= 0;
        end else if (!m_busy) begin
            if (gi() || gd()) begin
                m_busy <= 1; m_iss <= 0; m_ans <= 0; m_disc <= 0;
                m_ic <= gi(); m_last_ic <= gi();
                m_addr <= gi() ? ic_addr : dc_addr;
                m_we <= gd() && dc_we;
                m_wdata <= gi() ? 32'h0 : dc_wdata;
            end
        end else if (!m_iss) begin
            if (ic_flush && m_ic) m_disc <= 1;
            if (mem_req_ready) m_iss <= 1;
        end else if (!m_ans) begin
            if (mem_rsp_valid) begin
                m_rdata <= mem_rsp_data; m_raddr <= mem_rsp_addr; m_disc <= 0;
                if (m_disc || (ic_flush && m_ic)) m_busy <= 0;
                else m_ans <= 1;
            end else if (ic_flush && m_ic) m_disc <= 1;
        end else if (m_ic ? (ic_flush || ic_rsp_ready) : dc_rsp_ready) m_busy <= 0;
    end

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic cmp_all();
        chk("ic_req_ready_o", ic_req_ready_o, gi());
        chk("dc_req_ready_o", dc_req_ready_o, gd());
        chk("mem_req_valid_o", mem_req_valid_o, m_busy && !m_iss);
        chk("mem_rsp_ready_o", mem_rsp_ready_o, m_busy && m_iss && !m_ans);
        chk("ic_rsp_valid_o", ic_rsp_valid_o, m_busy && m_ans && m_ic && !ic_flush);
        chk("dc_rsp_valid_o", dc_rsp_valid_o, m_busy && m_ans && !m_ic);
        chk("mem_addr_o", mem_addr_o, m_addr);
        chk("mem_we_o", mem_we_o, m_we);
        chk("mem_wdata_o", mem_wdata_o, m_wdata);
        chk("ic_rsp_data_o", ic_rsp_data_o, m_rdata);
        chk("ic_rsp_addr_o", ic_rsp_addr_o, m_raddr);
        chk("dc_rsp_data_o", dc_rsp_data_o, m_rdata);
        if (ic_rsp_valid_o) ic_seen++;
    endtask

    task automatic cyc();
        @(negedge clk) cmp_all();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input bit ic, input logic [31:0] a, input bit we, input logic [31:0] d);
        if (ic) begin ic_req_valid = 1; ic_addr = a; end
        else begin dc_req_valid = 1; dc_addr = a; dc_we = we; dc_wdata = d; end
        #1;
        for (int i = 0; i < 20 && !(ic ? ic_req_ready_o : dc_req_ready_o); i++) cyc();
        if (ic ? ic_req_ready_o : dc_req_ready_o) begin
            cyc();
            if (ic) ic_req_valid = 0; else dc_req_valid = 0;
            dc_we = 0;
            chk("req_latency", mem_req_valid_o, 1);
            chk("req_addr", mem_addr_o, a);
        end else begin
            checks++; errors++;
            $display("FAIL req_timeout: ready never seen at %0t", $time);
        end
    endtask

    task automatic mem_txn(input int stall, input int dly, input logic [31:0] ea, input bit ewe,
                           input logic [31:0] d, input logic [31:0] ra);
        for (int i = 0; i < stall; i++) begin
            chk("stall_valid", mem_req_valid_o, 1);
            chk("stall_addr", mem_addr_o, ea);
            chk("stall_we", mem_we_o, ewe);
            chk("stall_req_ready", {ic_req_ready_o, dc_req_ready_o}, 0);
            cyc();
        end
        mem_req_ready = 1;
        cyc();
        mem_req_ready = 0;
        repeat (dly) cyc();
        chk("mem_rsp_ready", mem_rsp_ready_o, 1);
        mem_rsp_valid = 1; mem_rsp_data = d; mem_rsp_addr = ra;
        cyc();
        mem_rsp_valid = 0;
    endtask

    task automatic rsp_take(input bit ic, input int stall, input logic [31:0] d, input logic [31:0] ra);
        for (int i = 0; i < stall; i++) begin
            chk("rsp_hold_valid", ic ? ic_rsp_valid_o : dc_rsp_valid_o, 1);
            chk("rsp_hold_data", ic ? ic_rsp_data_o : dc_rsp_data_o, d);
            chk("rsp_hold_dc_ready", dc_req_ready_o, 0);
            cyc();
        end
        chk("rsp_valid", ic ? ic_rsp_valid_o : dc_rsp_valid_o, 1);
        chk("rsp_other_valid", ic ? dc_rsp_valid_o : ic_rsp_valid_o, 0);
        chk("rsp_data", ic ? ic_rsp_data_o : dc_rsp_data_o, d);
        if (ic) chk("rsp_addr", ic_rsp_addr_o, ra);
        if (ic) ic_rsp_ready = 1; else dc_rsp_ready = 1;
        cyc();
        ic_rsp_ready = 0; dc_rsp_ready = 0;
    endtask

    task automatic grant_serve(input bit g, input logic [31:0] d);
        logic [31:0] a;
        a = g ? ic_addr : dc_addr;
        #1;
        chk("grant_ic", ic_req_ready_o, g);
        chk("grant_dc", dc_req_ready_o, !g);
        cyc();
        if (g) ic_req_valid = 0; else dc_req_valid = 0;
        mem_txn(0, 0, a, 0, d, a);
        rsp_take(g, 0, d, a);
    endtask

    task automatic idle_probe(input string n);
        dc_req_valid = 1;
        #1;
        chk(n, dc_req_ready_o, 1);
        dc_req_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0;
        cyc(); cyc();
        chk("reset_outputs", {ic_req_ready_o, dc_req_ready_o, mem_req_valid_o, mem_rsp_ready_o,
                              ic_rsp_valid_o, dc_rsp_valid_o, mem_we_o}, 0);
        chk("reset_addr", mem_addr_o, 0);
        rst = 0;
        cyc();
        // ic-only fetch
        req(1, 32'h80000000, 0, 0);
        mem_txn(0, 1, 32'h80000000, 0, 32'h00000013, 32'h80000000);
        rsp_take(1, 0, 32'h00000013, 32'h80000000);
        // simultaneous ic + dc store: dc first
        ic_req_valid = 1; ic_addr = 32'h80000008;
        dc_req_valid = 1; dc_addr = 32'h1000; dc_we = 1; dc_wdata = 32'hDEADBEEF;
        #1;
        chk("pair_dc_wins", dc_req_ready_o, 1);
        chk("pair_ic_loses", ic_req_ready_o, 0);
        cyc();
        dc_req_valid = 0; dc_we = 0;
        chk("store_we", mem_we_o, 1);
        chk("store_wdata", mem_wdata_o, 32'hDEADBEEF);
        mem_txn(0, 0, 32'h1000, 1, 32'h0, 32'h1000);
        rsp_take(0, 0, 32'h0, 32'h1000);
        grant_serve(1, 32'h00100093);
        // back-to-back pairs: second pair differs between fixed and round-robin
        ic_req_valid = 1; ic_addr = 32'h8000000C;
        dc_req_valid = 1; dc_addr = 32'h1004;
        grant_serve(0, 32'h11);
        dc_req_valid = 1; dc_addr = 32'h1008;
        grant_serve(RR, RR ? 32'h22 : 32'h33);
        grant_serve(!RR, RR ? 32'h33 : 32'h22);
        // flush during WAIT discards the fetch
        s0 = ic_seen;
        req(1, 32'h80000004, 0, 0);
        mem_req_ready = 1;
        cyc();
        mem_req_ready = 0;
        ic_flush = 1;
        cyc();
        ic_flush = 0;
        cyc();
        chk("flush_rsp_ready", mem_rsp_ready_o, 1);
        mem_rsp_valid = 1; mem_rsp_data = 32'h0000006F; mem_rsp_addr = 32'h80000004;
        cyc();
        mem_rsp_valid = 0;
        cyc();
        chk("flush_no_ic_rsp", ic_seen - s0, 0);
        idle_probe("flush_back_idle");
        // flush while the response is being offered
        req(1, 32'h80000014, 0, 0);
        mem_txn(0, 0, 32'h80000014, 0, 32'h33, 32'h80000014);
        chk("rspflush_pre", ic_rsp_valid_o, 1);
        ic_flush = 1;
        #1;
        chk("rspflush_valid", ic_rsp_valid_o, 0);
        cyc();
        ic_flush = 0;
        idle_probe("rspflush_idle");
        // memory backpressure with both requesters waiting
        req(0, 32'h3000, 0, 0);
        ic_req_valid = 1; ic_addr = 32'h80000020;
        dc_req_valid = 1; dc_addr = 32'h3004;
        mem_txn(5, 0, 32'h3000, 0, 32'h77, 32'h3000);
        ic_req_valid = 0; dc_req_valid = 0;
        rsp_take(0, 0, 32'h77, 32'h3000);
        // icache response backpressure blocks a new dc request
        req(1, 32'h80000018, 0, 0);
        mem_txn(0, 0, 32'h80000018, 0, 32'h99, 32'h80000018);
        dc_req_valid = 1; dc_addr = 32'h4000;
        rsp_take(1, 3, 32'h99, 32'h80000018);
        grant_serve(0, 32'hAB);
        // asynchronous reset in WAIT
        req(1, 32'h80000010, 0, 0);
        mem_req_ready = 1;
        cyc();
        mem_req_ready = 0;
        #2 rst = 1;
        #1;
        chk("async_rst_outputs", {ic_req_ready_o, dc_req_ready_o, mem_req_valid_o, mem_rsp_ready_o,
                                  ic_rsp_valid_o, dc_rsp_valid_o, mem_we_o}, 0);
        chk("async_rst_addr", mem_addr_o, 0);
        cyc(); cyc();
        rst = 0;
        req(0, 32'h2000, 0, 0);
        mem_txn(0, 1, 32'h2000, 0, 32'h000055AA, 32'h2000);
        rsp_take(0, 0, 32'h000055AA, 32'h2000);
        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single instruction/data memory port between the icache refill path and the dcache. One transaction outstanding at a time.
- Sits between the two caches and the memory wrapper. Routes each response back to the requester that issued it.
- Provides an icache flush input so that wrong-path fetch responses after a taken branch are consumed and discarded.

Parameters:
ADDR_W, 32, address width of all request/response addresses
DATA_W, 32, data width of read data, write data and response data

Ports:
clk_i  in  1  clock; all state on rising edge
rst_i  in  1  asynchronous, active-high reset
ic_req_valid_i  in  1  icache read request valid
ic_req_ready_o  out  1  icache request accepted
ic_addr_i  in  ADDR_W  icache read address
ic_flush_i  in  1  taken-branch flush; drop any icache transaction
ic_rsp_valid_o  out  1  icache response valid
ic_rsp_ready_i  in  1  icache response consumed
ic_rsp_data_o  out  DATA_W  icache response instruction
ic_rsp_addr_o  out  ADDR_W  address the icache response belongs to
dc_req_valid_i  in  1  dcache request valid
dc_req_ready_o  out  1  dcache request accepted
dc_addr_i  in  ADDR_W  dcache address
dc_we_i  in  1  dcache write enable (1 = store)
dc_wdata_i  in  DATA_W  dcache store data
dc_rsp_valid_o  out  1  dcache response/ack valid
dc_rsp_ready_i  in  1  dcache response consumed
dc_rsp_data_o  out  DATA_W  dcache load data (don't-care for stores)
mem_req_valid_o  out  1  memory request valid
mem_req_ready_i  in  1  memory accepts request
mem_addr_o  out  ADDR_W  memory address
mem_we_o  out  1  memory write enable
mem_wdata_o  out  DATA_W  memory write data
mem_rsp_valid_i  in  1  memory response valid
mem_rsp_ready_o  out  1  arbiter accepts memory response
mem_rsp_data_i  in  DATA_W  memory response data
mem_rsp_addr_i  in  ADDR_W  memory response address

Behaviour:
- Reset: all outputs 0; FSM = IDLE; drop flag = 0; owner = DC; last_grant = IC; internal buffers = 0.
- Reset mid-transaction abandons it unconditionally. The memory side is reset by the same rst_i.
- A handshake completes on any cycle where valid and ready are both 1.
- FSM states: IDLE, REQ, WAIT, RSP.
- IDLE:
  - Grant is combinational. Only the winner gets req_ready_o = 1.
  - Fixed priority: dc over ic.
  - ic is not eligible in a cycle where ic_flush_i = 1.
  - On handshake, latch addr/we/wdata and owner (ic => we = 0, wdata = 0). Next state REQ.
- REQ:
  - mem_req_valid_o = 1 with the latched fields, held stable until mem_req_ready_i.
  - A request is never withdrawn, even on flush. Then WAIT.
  - mem_req_valid_o first rises in the cycle after the requester handshake (1-cycle latency).
- WAIT:
  - mem_rsp_ready_o = 1.
  - On mem_rsp_valid_i, capture data and addr. If drop = 1, go to IDLE and clear drop (response discarded). Otherwise go to RSP.
- RSP:
  - The owner's rsp_valid_o = 1 with buffered data, held until the owner's rsp_ready_i. Then IDLE.
  - The non-owner's rsp_valid_o = 0.
- Flush:
  - ic_flush_i = 1 while owner = IC in REQ or WAIT sets drop.
  - In RSP with owner = IC, flush forces ic_rsp_valid_o = 0 that cycle and goes to IDLE.
  - Flush has no effect on dc transactions.
- Throughput: at most one transaction per 4 cycles. There is no acceptance in the RSP->IDLE transition cycle.
- Request ready outputs are 0 in every state except IDLE.
- A dc store still waits for a memory response, which acts as the ack. dc_rsp_data_o = captured data.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- When defined: round-robin grant in IDLE. When both requesters are eligible, the one not equal to last_grant wins. last_grant updates on every accepted request.
- When undefined: fixed dc-over-ic priority; last_grant is unused.

Test Plan:
- ic only, addr 0x80000000; memory ready immediately, rsp data 0x00000013 after 2 cycles -> mem_req_valid_o one cycle after accept; ic_rsp_valid_o with data 0x00000013, addr 0x80000000; dc_rsp_valid_o stays 0.
- ic and dc request in the same cycle (dc store 0x1000, data 0xDEADBEEF) -> dc granted first, with mem_we_o = 1 and wdata 0xDEADBEEF; ic granted in the next IDLE. Under MEM_ARB_RR_EN, a second simultaneous pair grants ic.
- ic request at 0x80000004; ic_flush_i pulsed during WAIT -> memory response consumed (mem_rsp_ready_o = 1); ic_rsp_valid_o never asserts; FSM back in IDLE.
- mem_req_ready_i held 0 for 5 cycles -> mem_req_valid_o, mem_addr_o, mem_we_o stable all 5 cycles; both req_ready_o = 0.
- ic_rsp_ready_i held 0 for 3 cycles in RSP -> ic_rsp_valid_o and data stable; new dc request not accepted until RSP completes.
- rst_i asserted during WAIT -> all outputs 0 immediately (asynchronous). After release, a new dc load to 0x2000 completes normally.
